// File: rtl/timer_dev_if.sv
// Processor-side device bus as seen by one peripheral: select, write strobe,
// word address, write data and combinational read data.
interface timer_dev_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output sel, we, addr, din, input dout);
    modport slave  (input sel, we, addr, din, output dout);
endinterface

// File: rtl/timer_dev.sv
// Programmable interval timer: one-shot or auto-reload down-counter with an
// optional prescaler and a masked, registered interrupt request.
module timer_dev #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst,
    timer_dev_if.slave bus,
    output logic       irq
);

    localparam int unsigned      PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

    state_e           state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [31:0]      preset_q, preset_d;
    logic [31:0]      count_q, count_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             irq_flag_q, irq_flag_d;
    logic             irq_q, irq_d;
    logic             ctrl_wr, preset_wr, tick, reload;

    assign ctrl_wr   = bus.sel && bus.we && (bus.addr == 2'd0);
    assign preset_wr = bus.sel && bus.we && (bus.addr == 2'd1);
    assign tick      = (psc_q == PSC_LAST);
    assign reload    = (ctrl_q[2:1] == 2'b01);
    assign irq       = irq_q;

    always_comb begin
        case (bus.addr)
            2'd0:    bus.dout = {28'd0, ctrl_q};
            2'd1:    bus.dout = preset_q;
            2'd2:    bus.dout = count_q;
            default: bus.dout = 32'd0;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        psc_d      = psc_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            S_IDLE: if (ctrl_q[0]) state_d = S_LOAD;
            S_LOAD: begin
                count_d = preset_q;
                psc_d   = '0;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    psc_d = '0;
                    if (count_q <= 32'd1) begin
                        count_d    = 32'd0;
                        irq_flag_d = 1'b1;
                        state_d    = S_INT;
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end else begin
                    psc_d = psc_q + PSC_W'(1);
                end
            end
            S_INT: begin
                if (reload) begin
                    irq_flag_d = 1'b0;
                    state_d    = S_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes override hardware updates of CTRL and always drop the flag.
        if (ctrl_wr) begin
            ctrl_d     = bus.din[3:0];
            irq_flag_d = 1'b0;
        end
        if (preset_wr) preset_d = bus.din;

        irq_d = irq_flag_d & ctrl_d[3];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            psc_q      <= '0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            psc_q      <= psc_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: register-access table, hand-written
// timing sequences, and randomized runs against an arithmetic timing model.
`timescale 1ns/1ps
module tb_timer_dev;

    logic clk = 1'b0;
    logic rst;
    logic irq0, irq4;

    timer_dev_if bus0 ();
    timer_dev_if bus4 ();

    timer_dev #(.PRESCALE(1)) u_dut  (.clk(clk), .rst(rst), .bus(bus0), .irq(irq0));
    timer_dev #(.PRESCALE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4), .irq(irq4));

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit          sel;
        bit          we;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] count;
        bit          irq;
        bit          en;
    } exp_t;

    vec_t vec [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one bus cycle starting at a falling edge; returns one cycle later.
    task automatic drive(input bit d4, input bit sel, input bit we,
                         input logic [1:0] a, input logic [31:0] d);
        if (d4) begin
            bus4.sel = sel; bus4.we = we; bus4.addr = a; bus4.din = d;
        end else begin
            bus0.sel = sel; bus0.we = we; bus0.addr = a; bus0.din = d;
        end
        @(negedge clk);
        if (d4) begin
            bus4.sel = 1'b0; bus4.we = 1'b0;
        end else begin
            bus0.sel = 1'b0; bus0.we = 1'b0;
        end
    endtask

    task automatic wr(input bit d4, input logic [1:0] a, input logic [31:0] d);
        drive(d4, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input bit d4, input logic [1:0] a, output logic [31:0] v);
        if (d4) begin
            bus4.addr = a; #1; v = bus4.dout;
        end else begin
            bus0.addr = a; #1; v = bus0.dout;
        end
    endtask

    task automatic chk_rd(input bit d4, input logic [1:0] a, input logic [31:0] exp, input string name);
        logic [31:0] v;
        rd(d4, a, v);
        check(name, v, exp);
    endtask

    task automatic chk_irq(input bit d4, input bit exp, input string name);
        check(name, 32'(d4 ? irq4 : irq0), 32'(exp));
    endtask

    task automatic do_reset;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Expected view k edges after the CTRL write that set EN (timer freshly reset,
    // so COUNT is 0 before the first load). The counting phase lasts
    // max(N,1)*ps cycles, INT and LOAD one cycle each.
    function automatic exp_t predict(input int k, input int n, input int ps,
                                     input bit reload, input bit im);
        exp_t e;
        int   cnt_len, j;
        cnt_len = ((n < 1) ? 1 : n) * ps;
        e.count = 32'd0;
        e.irq   = 1'b0;
        e.en    = 1'b1;
        if (k < 2) return e;
        j = k - 2;
        if (reload) j = j % (cnt_len + 2);
        if (j < cnt_len) begin
            e.count = 32'(n - j / ps);
        end else begin
            e.irq = im && (reload ? (j == cnt_len) : 1'b1);
            e.en  = reload || (j == cnt_len);
        end
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus0.sel = 1'b0; bus0.we = 1'b0; bus0.addr = 2'd0; bus0.din = 32'd0;
        bus4.sel = 1'b0; bus4.we = 1'b0; bus4.addr = 2'd0; bus4.din = 32'd0;
        rst = 1'b0;
        #12;
        rst = 1'b1;
        @(negedge clk);

        // Register access table on the PRESCALE=1 instance (EN kept 0).
        vec[0]  = '{1'b0, 1'b0, 2'd0, 32'h0,         2'd0, 32'h0,         "rst_ctrl"};
        vec[1]  = '{1'b0, 1'b0, 2'd0, 32'h0,         2'd1, 32'h0,         "rst_preset"};
        vec[2]  = '{1'b0, 1'b0, 2'd0, 32'h0,         2'd2, 32'h0,         "rst_count"};
        vec[3]  = '{1'b1, 1'b1, 2'd1, 32'hA5A5_1234, 2'd1, 32'hA5A5_1234, "preset_rw"};
        vec[4]  = '{1'b1, 1'b1, 2'd0, 32'hFFFF_FFF6, 2'd0, 32'h6,         "ctrl_width"};
        vec[5]  = '{1'b1, 1'b1, 2'd2, 32'h1234,      2'd2, 32'h0,         "count_ro"};
        vec[6]  = '{1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0,         "addr3_zero"};
        vec[7]  = '{1'b0, 1'b1, 2'd1, 32'hDEAD_BEEF, 2'd1, 32'hA5A5_1234, "sel_low"};
        vec[8]  = '{1'b1, 1'b0, 2'd1, 32'hDEAD_BEEF, 2'd1, 32'hA5A5_1234, "we_low"};
        vec[9]  = '{1'b1, 1'b1, 2'd0, 32'h8,         2'd0, 32'h8,         "ctrl_im_only"};
        vec[10] = '{1'b1, 1'b1, 2'd1, 32'h0,         2'd1, 32'h0,         "preset_clear"};
        vec[11] = '{1'b0, 1'b0, 2'd0, 32'h0,         2'd0, 32'h8,         "ctrl_hold"};
        chk_irq(1'b0, 1'b0, "rst_irq");
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, vec[i].sel, vec[i].we, vec[i].waddr, vec[i].wdata);
            chk_rd(1'b0, vec[i].raddr, vec[i].exp, vec[i].name);
            chk_irq(1'b0, 1'b0, "tbl_irq");
        end

        // One-shot: irq 7 edges after the CTRL write, EN self-clears, CTRL write drops irq.
        do_reset;
        wr(1'b0, 2'd1, 32'd5);
        wr(1'b0, 2'd0, 32'h9);
        step(6);
        chk_irq(1'b0, 1'b0, "m0_irq_early");
        step(1);
        chk_irq(1'b0, 1'b1, "m0_irq_rise");
        step(3);
        chk_irq(1'b0, 1'b1, "m0_irq_hold");
        chk_rd(1'b0, 2'd0, 32'h8, "m0_en_clr");
        wr(1'b0, 2'd0, 32'h0);
        chk_irq(1'b0, 1'b0, "m0_irq_clr");

        // Auto-reload, PRESET=3: period 5, COUNT 3,2,1,0 then INT/LOAD.
        do_reset;
        wr(1'b0, 2'd1, 32'd3);
        wr(1'b0, 2'd0, 32'hB);
        for (int k = 0; k < 25; k++) begin
            chk_irq(1'b0, (k >= 5) && ((k - 5) % 5 == 0), "m1_irq");
            if (k >= 2) chk_rd(1'b0, 2'd2, ((k - 2) % 5 < 3) ? 32'(3 - (k - 2) % 5) : 32'd0, "m1_count");
            step(1);
        end
        wr(1'b0, 2'd0, 32'h0);

        // Masked one-shot: no irq, EN still self-clears.
        do_reset;
        wr(1'b0, 2'd1, 32'd2);
        wr(1'b0, 2'd0, 32'h1);
        for (int k = 0; k < 8; k++) begin
            chk_irq(1'b0, 1'b0, "mask_irq");
            step(1);
        end
        chk_rd(1'b0, 2'd0, 32'h0, "mask_en_clr");

        // Stop mid-count: the EN=0 write edge leaves COUNT=7, which then holds.
        do_reset;
        wr(1'b0, 2'd1, 32'd20);
        wr(1'b0, 2'd0, 32'h9);
        step(14);
        chk_rd(1'b0, 2'd2, 32'd8, "stop_pre");
        wr(1'b0, 2'd0, 32'h8);
        step(5);
        chk_rd(1'b0, 2'd2, 32'd7, "stop_count");
        chk_rd(1'b0, 2'd0, 32'h8, "stop_ctrl");
        chk_irq(1'b0, 1'b0, "stop_irq");

        // PRESET 0 and 1 both reach INT 3 edges after the CTRL write.
        for (int n = 0; n < 2; n++) begin
            do_reset;
            wr(1'b0, 2'd1, 32'(n));
            wr(1'b0, 2'd0, 32'h9);
            step(2);
            chk_irq(1'b0, 1'b0, "small_early");
            step(1);
            chk_irq(1'b0, 1'b1, "small_rise");
        end

        // Max PRESET decrements without wrap; COUNT writes are ignored.
        do_reset;
        wr(1'b0, 2'd1, 32'hFFFF_FFFF);
        wr(1'b0, 2'd0, 32'h1);
        step(2);
        chk_rd(1'b0, 2'd2, 32'hFFFF_FFFF, "max_load");
        step(1);
        chk_rd(1'b0, 2'd2, 32'hFFFF_FFFE, "max_dec");
        wr(1'b0, 2'd2, 32'd5);
        chk_rd(1'b0, 2'd2, 32'hFFFF_FFFD, "max_cnt_wr");
        chk_rd(1'b0, 2'd3, 32'h0, "max_addr3");

        // CTRL write on the edge that sets irq_flag: write wins, flag cleared.
        do_reset;
        wr(1'b0, 2'd1, 32'd3);
        wr(1'b0, 2'd0, 32'h9);
        step(4);
        wr(1'b0, 2'd0, 32'h8);
        chk_irq(1'b0, 1'b0, "coll_set_irq");
        chk_rd(1'b0, 2'd0, 32'h8, "coll_set_ctrl");
        step(1);
        chk_irq(1'b0, 1'b0, "coll_set_irq2");

        // CTRL write on the edge of the hardware EN clear: written EN survives.
        do_reset;
        wr(1'b0, 2'd1, 32'd3);
        wr(1'b0, 2'd0, 32'h9);
        step(5);
        chk_irq(1'b0, 1'b1, "coll_clr_pre");
        wr(1'b0, 2'd0, 32'h9);
        chk_rd(1'b0, 2'd0, 32'h9, "coll_clr_ctrl");
        chk_irq(1'b0, 1'b0, "coll_clr_irq");
        wr(1'b0, 2'd0, 32'h0);

        // Prescale 4, PRESET=2: irq after 2+8 edges.
        do_reset;
        wr(1'b1, 2'd1, 32'd2);
        wr(1'b1, 2'd0, 32'h9);
        step(9);
        chk_irq(1'b1, 1'b0, "psc_early");
        step(1);
        chk_irq(1'b1, 1'b1, "psc_rise");
        step(1);
        chk_rd(1'b1, 2'd0, 32'h8, "psc_en_clr");

        // PRESET write mid-count does not touch the running COUNT.
        do_reset;
        wr(1'b1, 2'd1, 32'd10);
        wr(1'b1, 2'd0, 32'h1);
        step(2);
        chk_rd(1'b1, 2'd2, 32'd10, "pw_load");
        wr(1'b1, 2'd1, 32'd3);
        chk_rd(1'b1, 2'd2, 32'd10, "pw_hold");
        step(3);
        chk_rd(1'b1, 2'd2, 32'd9, "pw_dec");
        chk_rd(1'b1, 2'd1, 32'd3, "pw_preset");

        // Asynchronous reset with irq high and the other timer mid-count.
        do_reset;
        wr(1'b0, 2'd1, 32'd2);
        wr(1'b0, 2'd0, 32'h9);
        wr(1'b1, 2'd1, 32'd100);
        wr(1'b1, 2'd0, 32'h1);
        step(3);
        chk_irq(1'b0, 1'b1, "arst_pre_irq");
        chk_rd(1'b1, 2'd1, 32'd100, "arst_pre_preset");
        #1;
        rst = 1'b0;
        #1;
        chk_irq(1'b0, 1'b0, "arst_irq");
        for (int a = 0; a < 4; a++) begin
            chk_rd(1'b0, 2'(a), 32'h0, "arst_reg0");
            chk_rd(1'b1, 2'(a), 32'h0, "arst_reg4");
        end
        rst = 1'b1;
        @(negedge clk);

        // Randomized programs against the timing model.
        for (int t = 0; t < 24; t++) begin
            int          n, ps, lim;
            bit          d4, im, rl;
            logic [1:0]  mode;
            logic [31:0] v;
            exp_t        e;
            n    = int'($urandom_range(0, 9));
            mode = 2'($urandom_range(0, 3));
            im   = 1'($urandom_range(0, 1));
            d4   = 1'($urandom_range(0, 1));
            ps   = d4 ? 4 : 1;
            rl   = (mode == 2'd1);
            lim  = 2 * (((n < 1) ? 1 : n) * ps + 2) + 3;
            do_reset;
            wr(d4, 2'd1, 32'(n));
            wr(d4, 2'd0, {28'd0, im, mode, 1'b1});
            for (int k = 0; k <= lim; k++) begin
                e = predict(k, n, ps, rl, im);
                rd(d4, 2'd2, v);
                check("rnd_count", v, e.count);
                chk_irq(d4, e.irq, "rnd_irq");
                rd(d4, 2'd0, v);
                check("rnd_ctrl", v, {28'd0, im, mode, e.en});
                step(1);
            end
            wr(d4, 2'd0, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
